gpio_multi: RTL
===============

# gpio_multi

Parametrised GPIO controller and successor to the current GPIO core. It supports up to 32 pins, atomic set/clear/toggle of outputs, per-pin input synchronisation with a programmable debounce counter, and four interrupt sources per pin (rising, falling, high level, low level). Interrupts collect into a write-1-to-clear status register and drive one interrupt line per pin plus an aggregate line. It sits on the peripheral register bus alongside the other perips blocks.

## Interface
- GPIO_NUM, 16, number of pins, 1..32; register bits at index GPIO_NUM and above read 0 and ignore writes.
- FILT_W, 16, width of the debounce threshold and of each per-pin counter.
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- gpio_oe_o  out  GPIO_NUM  output enable; reset 0.
- gpio_data_o  out  GPIO_NUM  output data; reset 0.
- gpio_data_i  in  GPIO_NUM  pad input, asynchronous to clk_i.
- irq_o  out  GPIO_NUM  per-pin interrupt, equals INT_STATE; reset 0.
- irq_any_o  out  1  OR of irq_o; reset 0.
- reg_we_i / reg_re_i  in  1  register write / read strobe.
- reg_wdata_i  in  32  write data.
- reg_be_i  in  4  byte enables; only enabled bytes are written.
- reg_addr_i  in  32  byte address; bits [5:2] decode the register.
- reg_rdata_o  out  32  read data; combinational, same cycle as reg_re_i; 0 when reg_re_i is low or the address is unmapped.

## Operation
- Register map (word offsets):
  - 0x00 OE (RW)
  - 0x04 OUT (RW)
  - 0x08 OUT_SET (W1S, reads 0)
  - 0x0C OUT_CLR (W1C on OUT, reads 0)
  - 0x10 OUT_TGL (write 1 to toggle, reads 0)
  - 0x14 IN (RO, filtered value)
  - 0x18 FILT_EN (RW)
  - 0x1C FILT_CNT (RW, FILT_W bits)
  - 0x20 INT_RISE_EN, 0x24 INT_FALL_EN, 0x28 INT_HIGH_EN, 0x2C INT_LOW_EN (all RW)
  - 0x30 INT_STATE (RW1C)
- Unmapped addresses: writes are ignored, reads return 0. Every register resets to 0.
- Input path per pin: 2-flop synchroniser, then debounce, then filtered value `f`.
  - Debounce with FILT_EN[i]=0: `f` follows the synchroniser output with 1 flop.
  - Debounce with FILT_EN[i]=1: the counter clears whenever the synchronised input equals `f`. Otherwise it increments; when the count reaches FILT_CNT, `f` takes the new value and the counter clears.
  - FILT_CNT=0 behaves as if filtering were disabled.
  - Writing FILT_CNT or FILT_EN mid-count does not clear counters; the new threshold applies from the next cycle.
- Event per pin: (rise & RISE_EN) | (fall & FALL_EN) | (f & HIGH_EN) | (~f & LOW_EN).
  - rise and fall are computed against `f` delayed by one cycle.
- INT_STATE[i] is set on an event and cleared by writing 1.
  - A set and a clear in the same cycle: set wins.
  - Level sources re-assert every cycle while the condition holds.
- Output update priority when writes coincide with nothing else: only one bus write per cycle, so no conflict exists between OUT, SET, CLR and TGL.
- Pins configured as outputs are still sampled into IN, which gives a readback path.

## Timing
- Pad change to IN update:
  - Filter disabled: 3 cycles (2 sync + 1).
  - Filter enabled: 3 + FILT_CNT cycles for an input held stable.
- IN update to INT_STATE set: 1 cycle. irq_o is INT_STATE directly.
- Register write takes effect on gpio_*_o and INT_STATE at the next clock edge.
- A pulse shorter than FILT_CNT cycles with the filter enabled produces no IN change and no edge interrupt.
- Reset assertion mid-count: counters, sync flops, `f`, and all registers go to 0 immediately. After reset, a pad held high produces a rise event 3 cycles later if RISE_EN is set.

## Configuration
- GPIO_MULTI_FILTER_EN defined: the debounce counters and the FILT_EN/FILT_CNT registers are implemented as described above.
- GPIO_MULTI_FILTER_EN undefined:
  - No counters are built.
  - FILT_EN and FILT_CNT read 0 and ignore writes.
  - Every pin behaves as if FILT_EN=0, with the 3-cycle latency.

## Structure
- Package gpio_multi_pkg holds:
  - register offset localparams (GPIO_OE_OFFSET … GPIO_INT_STATE_OFFSET);
  - the register index enum;
  - the interrupt-source bit positions.
- Sub-module gpio_debounce (one instance per pin, parameter FILT_W) contains the synchroniser, the counter and the `f` register. Under GPIO_MULTI_FILTER_EN undefined it reduces to sync plus 1 flop.
- Top level contains register decode, write masking, interrupt logic and the read mux.

## Test plan
- Write OE=0x0000_FFFF, OUT=0x00AA; then OUT_SET=0x0100, OUT_CLR=0x0002, OUT_TGL=0x0001 -> gpio_data_o=0x01A9, OUT reads 0x01A9, OUT_SET reads 0.
- FILT_EN[3]=1, FILT_CNT=10; pad 3 pulses high for 8 cycles -> IN[3] stays 0. Pad held high for 20 cycles -> IN[3]=1 exactly 13 cycles after the pad edge.
- RISE_EN[5]=1; pad 5 goes 0→1 -> INT_STATE[5]=1 and irq_o[5]=1 at cycle 4, irq_any_o=1. Write INT_STATE=0x20 -> cleared. No re-set while the pad stays high.
- HIGH_EN[0]=1 with pad 0 held high; write 1 to clear INT_STATE[0] -> bit stays 1 (set wins). Drop the pad, then clear -> 0.
- Write with reg_be_i=4'b0010 and wdata=0xFFFF_FFFF to OUT -> only bits [15:8] change. Read offset 0x3C -> 0.
- Assert rst_ni mid-debounce with FILT_CNT=100 -> all outputs 0 asynchronously. After release, FILT_CNT reads 0.

Source files
------------

// File: rtl/gpio_multi_pkg.sv
// Shared definitions for the gpio_multi controller: register offsets, register index and interrupt source bits.
package gpio_multi_pkg;

   localparam logic [31:0] GPIO_OE_OFFSET          = 32'h00;
   localparam logic [31:0] GPIO_OUT_OFFSET         = 32'h04;
   localparam logic [31:0] GPIO_OUT_SET_OFFSET     = 32'h08;
   localparam logic [31:0] GPIO_OUT_CLR_OFFSET     = 32'h0C;
   localparam logic [31:0] GPIO_OUT_TGL_OFFSET     = 32'h10;
   localparam logic [31:0] GPIO_IN_OFFSET          = 32'h14;
   localparam logic [31:0] GPIO_FILT_EN_OFFSET     = 32'h18;
   localparam logic [31:0] GPIO_FILT_CNT_OFFSET    = 32'h1C;
   localparam logic [31:0] GPIO_INT_RISE_EN_OFFSET = 32'h20;
   localparam logic [31:0] GPIO_INT_FALL_EN_OFFSET = 32'h24;
   localparam logic [31:0] GPIO_INT_HIGH_EN_OFFSET = 32'h28;
   localparam logic [31:0] GPIO_INT_LOW_EN_OFFSET  = 32'h2C;
   localparam logic [31:0] GPIO_INT_STATE_OFFSET   = 32'h30;

   typedef enum logic [3:0] {
      REG_OE          = GPIO_OE_OFFSET[5:2],
      REG_OUT         = GPIO_OUT_OFFSET[5:2],
      REG_OUT_SET     = GPIO_OUT_SET_OFFSET[5:2],
      REG_OUT_CLR     = GPIO_OUT_CLR_OFFSET[5:2],
      REG_OUT_TGL     = GPIO_OUT_TGL_OFFSET[5:2],
      REG_IN          = GPIO_IN_OFFSET[5:2],
      REG_FILT_EN     = GPIO_FILT_EN_OFFSET[5:2],
      REG_FILT_CNT    = GPIO_FILT_CNT_OFFSET[5:2],
      REG_INT_RISE_EN = GPIO_INT_RISE_EN_OFFSET[5:2],
      REG_INT_FALL_EN = GPIO_INT_FALL_EN_OFFSET[5:2],
      REG_INT_HIGH_EN = GPIO_INT_HIGH_EN_OFFSET[5:2],
      REG_INT_LOW_EN  = GPIO_INT_LOW_EN_OFFSET[5:2],
      REG_INT_STATE   = GPIO_INT_STATE_OFFSET[5:2]
   } gpio_reg_e;

   localparam int INT_SRC_RISE = 0;
   localparam int INT_SRC_FALL = 1;
   localparam int INT_SRC_HIGH = 2;
   localparam int INT_SRC_LOW  = 3;
   localparam int INT_SRC_NUM  = 4;

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin input path: 2-flop synchroniser followed by the debounced value f_o.
// With GPIO_MULTI_FILTER_EN undefined no counter is built and f_o is the synchroniser output plus one flop.
module gpio_debounce #(
   parameter int FILT_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              pad_i,
`ifdef GPIO_MULTI_FILTER_EN
   input  logic              filt_en_i,
   input  logic [FILT_W-1:0] filt_cnt_i,
`endif
   output logic              f_o
);

   logic sync_p0, sync_p1, f_p2;

   // stage 0/1: metastability synchroniser
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= pad_i;
         sync_p1 <= sync_p0;
      end
   end

`ifdef GPIO_MULTI_FILTER_EN
   logic [FILT_W-1:0] cnt_q;

   // stage 2: the counter only holds its value while filtering is off, so re-enabling resumes the count
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         f_p2  <= 1'b0;
      end else if (!filt_en_i) begin
         f_p2 <= sync_p1;
      end else if (sync_p1 == f_p2) begin
         cnt_q <= '0;
      end else if (cnt_q >= filt_cnt_i) begin
         f_p2  <= sync_p1;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + FILT_W'(1);
      end
   end
`else
   logic [FILT_W-1:0] unused_cnt;
   assign unused_cnt = '0;

   // stage 2: plain register behind the synchroniser
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) f_p2 <= 1'b0;
      else         f_p2 <= sync_p1;
   end
`endif

   assign f_o = f_p2;

endmodule

// File: rtl/gpio_multi.sv
// GPIO controller top: register decode, byte-masked writes, interrupt collection and read mux.
// Define GPIO_MULTI_FILTER_EN to build the debounce counters and the FILT_EN/FILT_CNT registers.
module gpio_multi
   import gpio_multi_pkg::*;
#(
   parameter int GPIO_NUM = 16,
   parameter int FILT_W   = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   output logic [GPIO_NUM-1:0] gpio_oe_o,
   output logic [GPIO_NUM-1:0] gpio_data_o,
   input  logic [GPIO_NUM-1:0] gpio_data_i,
   output logic [GPIO_NUM-1:0] irq_o,
   output logic                irq_any_o,
   input  logic                reg_we_i,
   input  logic                reg_re_i,
   input  logic [31:0]         reg_wdata_i,
   input  logic [3:0]          reg_be_i,
   input  logic [31:0]         reg_addr_i,
   output logic [31:0]         reg_rdata_o
);

   logic [GPIO_NUM-1:0] oe_q, out_q, rise_en_q, fall_en_q, high_en_q, low_en_q, int_state_q;
   logic [GPIO_NUM-1:0] f, f_d1, evt, wmask, wbits, int_clr;
   logic [31:0]         bmask, rdata;
   gpio_reg_e           reg_idx;
   logic                unused_bits;

`ifdef GPIO_MULTI_FILTER_EN
   logic [GPIO_NUM-1:0] filt_en_q;
   logic [FILT_W-1:0]   filt_cnt_q;
`endif

   function automatic logic [GPIO_NUM-1:0] merge(input logic [GPIO_NUM-1:0] cur,
                                                 input logic [GPIO_NUM-1:0] bits,
                                                 input logic [GPIO_NUM-1:0] mask);
      return (cur & ~mask) | bits;
   endfunction

   assign reg_idx     = gpio_reg_e'(reg_addr_i[5:2]);
   assign bmask       = {{8{reg_be_i[3]}}, {8{reg_be_i[2]}}, {8{reg_be_i[1]}}, {8{reg_be_i[0]}}};
   assign wmask       = bmask[GPIO_NUM-1:0];
   assign wbits       = reg_wdata_i[GPIO_NUM-1:0] & wmask;
   assign int_clr     = (reg_we_i && reg_idx == REG_INT_STATE) ? wbits : '0;
   assign unused_bits = ^{reg_addr_i[31:6], reg_addr_i[1:0], reg_wdata_i, bmask};

   for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
      logic [INT_SRC_NUM-1:0] src, en;

      gpio_debounce #(.FILT_W(FILT_W)) u_debounce (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .pad_i      (gpio_data_i[i]),
`ifdef GPIO_MULTI_FILTER_EN
         .filt_en_i  (filt_en_q[i]),
         .filt_cnt_i (filt_cnt_q),
`endif
         .f_o        (f[i])
      );

      assign src[INT_SRC_RISE] = f[i] & ~f_d1[i];
      assign src[INT_SRC_FALL] = ~f[i] & f_d1[i];
      assign src[INT_SRC_HIGH] = f[i];
      assign src[INT_SRC_LOW]  = ~f[i];
      assign en[INT_SRC_RISE]  = rise_en_q[i];
      assign en[INT_SRC_FALL]  = fall_en_q[i];
      assign en[INT_SRC_HIGH]  = high_en_q[i];
      assign en[INT_SRC_LOW]   = low_en_q[i];
      assign evt[i]            = |(src & en);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         oe_q        <= '0;
         out_q       <= '0;
         rise_en_q   <= '0;
         fall_en_q   <= '0;
         high_en_q   <= '0;
         low_en_q    <= '0;
         int_state_q <= '0;
         f_d1        <= '0;
`ifdef GPIO_MULTI_FILTER_EN
         filt_en_q   <= '0;
         filt_cnt_q  <= '0;
`endif
      end else begin
         f_d1        <= f;
         // a new event overrides a simultaneous clear
         int_state_q <= (int_state_q & ~int_clr) | evt;
         if (reg_we_i) begin
            case (reg_idx)
               REG_OE:          oe_q      <= merge(oe_q, wbits, wmask);
               REG_OUT:         out_q     <= merge(out_q, wbits, wmask);
               REG_OUT_SET:     out_q     <= out_q | wbits;
               REG_OUT_CLR:     out_q     <= out_q & ~wbits;
               REG_OUT_TGL:     out_q     <= out_q ^ wbits;
`ifdef GPIO_MULTI_FILTER_EN
               REG_FILT_EN:     filt_en_q <= merge(filt_en_q, wbits, wmask);
               REG_FILT_CNT:    filt_cnt_q <= (filt_cnt_q & ~bmask[FILT_W-1:0]) |
                                              (reg_wdata_i[FILT_W-1:0] & bmask[FILT_W-1:0]);
`endif
               REG_INT_RISE_EN: rise_en_q <= merge(rise_en_q, wbits, wmask);
               REG_INT_FALL_EN: fall_en_q <= merge(fall_en_q, wbits, wmask);
               REG_INT_HIGH_EN: high_en_q <= merge(high_en_q, wbits, wmask);
               REG_INT_LOW_EN:  low_en_q  <= merge(low_en_q, wbits, wmask);
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (reg_re_i) begin
         case (reg_idx)
            REG_OE:          rdata[GPIO_NUM-1:0] = oe_q;
            REG_OUT:         rdata[GPIO_NUM-1:0] = out_q;
            REG_IN:          rdata[GPIO_NUM-1:0] = f;
`ifdef GPIO_MULTI_FILTER_EN
            REG_FILT_EN:     rdata[GPIO_NUM-1:0] = filt_en_q;
            REG_FILT_CNT:    rdata[FILT_W-1:0]   = filt_cnt_q;
`endif
            REG_INT_RISE_EN: rdata[GPIO_NUM-1:0] = rise_en_q;
            REG_INT_FALL_EN: rdata[GPIO_NUM-1:0] = fall_en_q;
            REG_INT_HIGH_EN: rdata[GPIO_NUM-1:0] = high_en_q;
            REG_INT_LOW_EN:  rdata[GPIO_NUM-1:0] = low_en_q;
            REG_INT_STATE:   rdata[GPIO_NUM-1:0] = int_state_q;
            default: ;
         endcase
      end
   end

   assign reg_rdata_o = rdata;
   assign gpio_oe_o   = oe_q;
   assign gpio_data_o = out_q;
   assign irq_o       = int_state_q;
   assign irq_any_o   = |int_state_q;

endmodule
